// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel decoder.
//   SYM_W / BYTE_W : symbol and decoded byte widths
//   CTRL_TOK_xx    : the four blanking control tokens, indexed by {c1,c0}
//   lock_state_t   : word-alignment lock FSM states
package tmds_pkg;

  localparam int SYM_W  = 10;
  localparam int BYTE_W = 8;

  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH,
    COUNT,
    LOCKED,
    SLIP_WAIT
  } lock_state_t;

endpackage

// File: rtl/tmds_decoder_if.sv
// Symbol bus between the deserializer, the TMDS decoder and the timing
// recovery logic.
//   tmds_in/valid_in            : received symbol from the deserializer
//   data_out/ctrl_out/de_out    : decoded pixel byte or control code
//   valid_out/err_out           : output qualifier and re-encode error flag
//   locked_out/bitslip_out      : alignment status and slip request
// master = symbol source / result consumer, slave = decoder.
interface tmds_decoder_if;
  import tmds_pkg::*;

  logic [SYM_W-1:0]  tmds_in;
  logic              valid_in;
  logic [BYTE_W-1:0] data_out;
  logic [1:0]        ctrl_out;
  logic              de_out;
  logic              valid_out;
  logic              err_out;
  logic              locked_out;
  logic              bitslip_out;

  modport master (
    output tmds_in, valid_in,
    input  data_out, ctrl_out, de_out, valid_out, err_out, locked_out, bitslip_out
  );

  modport slave (
    input  tmds_in, valid_in,
    output data_out, ctrl_out, de_out, valid_out, err_out, locked_out, bitslip_out
  );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder.
//   sym  : 10-bit received symbol
//   de   : 1 = data symbol, 0 = control token
//   ctrl : {c1,c0} for control tokens, 0 for data
//   data : decoded byte for data symbols, 0 for tokens
//   err  : the data symbol uses the XOR/XNOR mode the encoder would not
//          have chosen for this byte
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0]  sym,
  output logic              de,
  output logic [1:0]        ctrl,
  output logic [BYTE_W-1:0] data,
  output logic              err
);

  logic [BYTE_W-1:0] d;
  logic [BYTE_W-1:0] dec;
  logic [3:0]        ones;
  logic              xnor_exp;

  always_comb begin
    d   = sym[9] ? ~sym[7:0] : sym[7:0];
    dec = '0;
    dec[0] = d[0];
    for (int i = 1; i < BYTE_W; i++) begin
      dec[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    ones = 4'($countones(dec));
    // Encoder picks XNOR for heavy bytes, ties broken by bit 0 being clear.
    xnor_exp = (ones > 4'd4) || ((ones == 4'd4) && !dec[0]);

    de   = 1'b1;
    ctrl = 2'b00;
    data = dec;
    // bit 8 set means XOR was used; mismatch with the expected mode is an error
    err  = (xnor_exp == sym[8]);

    case (sym)
      CTRL_TOK_00: begin de = 1'b0; ctrl = 2'b00; data = '0; err = 1'b0; end
      CTRL_TOK_01: begin de = 1'b0; ctrl = 2'b01; data = '0; err = 1'b0; end
      CTRL_TOK_10: begin de = 1'b0; ctrl = 2'b10; data = '0; err = 1'b0; end
      CTRL_TOK_11: begin de = 1'b0; ctrl = 2'b11; data = '0; err = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder with word-alignment lock FSM.
//   clk_in      : symbol clock
//   rst_n_in    : asynchronous reset, active low
//   bus (slave) : tmds_in/valid_in in; data_out, ctrl_out, de_out,
//                 valid_out, err_out, locked_out, bitslip_out out
// Two register stages: p1 captures the raw symbol, p2 holds the decode.
// The lock FSM advances on the same edge as p2, one step per valid symbol.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT     = 4,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int ERR_LIMIT      = 8,
  parameter int SLIP_WAIT      = 16
)(
  input  logic          clk_in,
  input  logic          rst_n_in,
  tmds_decoder_if.slave bus
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int TOW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int ECW = $clog2(ERR_LIMIT + 1);
  localparam int SWW = $clog2(SLIP_WAIT + 1);

  localparam logic [LCW-1:0] LC_MAX = LCW'(LOCK_COUNT);
  localparam logic [TOW-1:0] TO_MAX = TOW'(SEARCH_TIMEOUT);
  localparam logic [ECW-1:0] EC_MAX = ECW'(ERR_LIMIT);
  localparam logic [SWW-1:0] SW_MAX = SWW'(SLIP_WAIT);

  logic [SYM_W-1:0]  tmds_p1;
  logic              vld_p1;

  logic              dec_de;
  logic [1:0]        dec_ctrl;
  logic [BYTE_W-1:0] dec_data;
  logic              dec_err;

  logic [BYTE_W-1:0] data_p2;
  logic [1:0]        ctrl_p2;
  logic              de_p2;
  logic              err_p2;
  logic              vld_p2;
  logic              locked_p2;
  logic              slip_p2;

  lock_state_t       state_q, state_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d, lock_inc;
  logic [TOW-1:0]    to_cnt_q, to_cnt_d, to_inc;
  logic [ECW-1:0]    err_cnt_q, err_cnt_d, err_inc;
  logic [SWW-1:0]    wait_cnt_q, wait_cnt_d, wait_inc;
  logic              slip;

  // ---- stage p1: raw symbol capture ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      tmds_p1 <= bus.tmds_in;
      vld_p1  <= bus.valid_in;
    end
  end

  tmds_symbol_decode u_decode (
    .sym  (tmds_p1),
    .de   (dec_de),
    .ctrl (dec_ctrl),
    .data (dec_data),
    .err  (dec_err)
  );

  assign lock_inc = (lock_cnt_q == LC_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);
  assign to_inc   = (to_cnt_q   == TO_MAX) ? to_cnt_q   : to_cnt_q   + TOW'(1);
  assign err_inc  = (err_cnt_q  == EC_MAX) ? err_cnt_q  : err_cnt_q  + ECW'(1);
  assign wait_inc = (wait_cnt_q == SW_MAX) ? wait_cnt_q : wait_cnt_q + SWW'(1);

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_cnt_d  = err_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip       = 1'b0;

    if (vld_p1) begin
      case (state_q)
        SEARCH, COUNT: begin
          // Timeout outranks a lock completing on the same symbol.
          if (to_inc == TO_MAX) begin
            slip       = 1'b1;
            state_d    = tmds_pkg::SLIP_WAIT;
            to_cnt_d   = '0;
            lock_cnt_d = '0;
            wait_cnt_d = '0;
          end else begin
            to_cnt_d = to_inc;
            if (!dec_de) begin
              lock_cnt_d = lock_inc;
              state_d    = COUNT;
              if (lock_inc == LC_MAX) begin
                state_d    = LOCKED;
                lock_cnt_d = '0;
                to_cnt_d   = '0;
                err_cnt_d  = '0;
              end
            end else begin
              state_d    = SEARCH;
              lock_cnt_d = '0;
            end
          end
        end

        LOCKED: begin
          if (!dec_de) begin
            err_cnt_d = '0;
          end else if (dec_err) begin
            if (err_inc == EC_MAX) begin
              slip       = 1'b1;
              state_d    = tmds_pkg::SLIP_WAIT;
              err_cnt_d  = '0;
              wait_cnt_d = '0;
            end else begin
              err_cnt_d = err_inc;
            end
          end
        end

        tmds_pkg::SLIP_WAIT: begin
          if (wait_inc == SW_MAX) begin
            state_d    = SEARCH;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end

        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= SEARCH;
      lock_cnt_q <= '0;
      to_cnt_q   <= '0;
      err_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      to_cnt_q   <= to_cnt_d;
      err_cnt_q  <= err_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---- stage p2: decoded outputs, lock status and slip pulse ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_p2   <= '0;
      ctrl_p2   <= '0;
      de_p2     <= 1'b0;
      err_p2    <= 1'b0;
      vld_p2    <= 1'b0;
      locked_p2 <= 1'b0;
      slip_p2   <= 1'b0;
    end else begin
      vld_p2    <= vld_p1;
      locked_p2 <= (state_d == LOCKED);
      slip_p2   <= slip;
      if (vld_p1) begin
        data_p2 <= dec_data;
        ctrl_p2 <= dec_ctrl;
        de_p2   <= dec_de;
        err_p2  <= dec_err;
      end
    end
  end

  assign bus.data_out    = data_p2;
  assign bus.ctrl_out    = ctrl_p2;
  assign bus.de_out      = de_p2;
  assign bus.err_out     = err_p2;
  assign bus.valid_out   = vld_p2;
  assign bus.locked_out  = locked_p2;
  assign bus.bitslip_out = slip_p2;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: table-driven decode vectors through a
// scoreboard queue, plus hand-written lock / timeout / loss-of-lock sequences.
module tb_tmds_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tmds_decoder_if bus();

  tmds_decoder #(
    .LOCK_COUNT     (4),
    .SEARCH_TIMEOUT (64),
    .ERR_LIMIT      (8),
    .SLIP_WAIT      (16)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [9:0] sym;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
  } exp_t;

  localparam logic [9:0] TOK = 10'h354;

  vec_t tbl[13];
  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   slips = 0;
  int   s0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  function automatic vec_t lookup(input logic [9:0] s);
    vec_t r;
    r = tbl[0];
    for (int i = 0; i < 13; i++) if (tbl[i].sym == s) r = tbl[i];
    return r;
  endfunction

  // Scoreboard: pop one expectation per valid_out and compare.
  always @(negedge clk) begin
    exp_t e;
    if (bus.bitslip_out) slips++;
    if (bus.valid_out) begin
      if (q.size() == 0) begin
        chk("unexpected_valid_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("decode_%03h", e.v.sym),
            {20'd0, bus.de_out, bus.ctrl_out, bus.data_out, bus.err_out},
            {20'd0, e.v.de, e.v.ctrl, e.v.data, e.v.err});
        chk($sformatf("latency_%03h", e.v.sym), cyc - e.cyc, 32'd2);
      end
    end
  end

  task automatic send(input logic [9:0] s, input logic v);
    exp_t e;
    @(negedge clk);
    bus.tmds_in  = s;
    bus.valid_in = v;
    if (v) begin
      e.v   = lookup(s);
      e.cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(10'h000, 1'b0);
  endtask

  task automatic tok_b();
    send(TOK, 1'b1);
    send(10'h000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("reset_outputs_zero",
        {17'd0, bus.data_out, bus.ctrl_out, bus.de_out, bus.valid_out,
         bus.err_out, bus.locked_out, bus.bitslip_out}, 32'd0);
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{10'h354, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{10'h0AB, 1'b0, 2'd1, 8'h00, 1'b0};
    tbl[2]  = '{10'h154, 1'b0, 2'd2, 8'h00, 1'b0};
    tbl[3]  = '{10'h2AB, 1'b0, 2'd3, 8'h00, 1'b0};
    tbl[4]  = '{10'h100, 1'b1, 2'd0, 8'h00, 1'b0};
    tbl[5]  = '{10'h000, 1'b1, 2'd0, 8'hFE, 1'b0};
    tbl[6]  = '{10'h155, 1'b1, 2'd0, 8'hFF, 1'b1};
    tbl[7]  = '{10'h3FF, 1'b1, 2'd0, 8'h00, 1'b0};
    tbl[8]  = '{10'h2FF, 1'b1, 2'd0, 8'hFE, 1'b0};
    tbl[9]  = '{10'h0FF, 1'b1, 2'd0, 8'hFF, 1'b0};
    tbl[10] = '{10'h1FF, 1'b1, 2'd0, 8'h01, 1'b0};
    tbl[11] = '{10'h10A, 1'b1, 2'd0, 8'h1E, 1'b1};
    tbl[12] = '{10'h105, 1'b1, 2'd0, 8'h0F, 1'b0};

    bus.tmds_in  = '0;
    bus.valid_in = 1'b0;

    // Table vectors, back to back and then with bubbles
    do_reset();
    for (int i = 0; i < 13; i++) send(tbl[i].sym, 1'b1);
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].sym, 1'b1);
      idle(i % 3);
    end
    idle(3);

    // Lock on the 4th token, bubbles in between
    do_reset();
    repeat (3) tok_b();
    idle(1);
    chk("no_lock_after_3", bus.locked_out, 1'b0);
    send(TOK, 1'b1);
    idle(2);
    chk("lock_with_4th_vld", bus.valid_out, 1'b1);
    chk("lock_with_4th", bus.locked_out, 1'b1);

    // Data symbol at cnt=3 restarts the search
    do_reset();
    repeat (3) tok_b();
    send(10'h100, 1'b1);
    repeat (3) tok_b();
    idle(1);
    chk("data_resets_count", bus.locked_out, 1'b0);
    tok_b();
    idle(1);
    chk("relock_after_data", bus.locked_out, 1'b1);

    // Reset mid-lock drops lock at once; FSM restarts in SEARCH
    do_reset();
    chk("reset_drops_lock", bus.locked_out, 1'b0);
    repeat (3) tok_b();
    idle(1);
    chk("search_after_reset", bus.locked_out, 1'b0);
    tok_b();
    idle(1);
    chk("lock_after_reset", bus.locked_out, 1'b1);

    // Loss of lock: 7 errors then a token keep lock; 8 in a row drop it
    s0 = slips;
    repeat (7) send(10'h155, 1'b1);
    send(TOK, 1'b1);
    repeat (4) send(10'h155, 1'b1);
    idle(1);
    repeat (3) send(10'h155, 1'b1);
    idle(2);
    chk("lock_held_7_errs", bus.locked_out, 1'b1);
    idle(1);
    chk("no_slip_7_errs", slips - s0, 32'd0);
    send(10'h155, 1'b1);
    idle(2);
    chk("lock_lost_8_errs", bus.locked_out, 1'b0);
    idle(1);
    chk("slip_on_err_limit", slips - s0, 32'd1);
    idle(2);

    // Search timeout: 64 data symbols -> one slip, then 16 ignored symbols
    do_reset();
    s0 = slips;
    repeat (63) send(10'h100, 1'b1);
    idle(3);
    chk("no_slip_at_63", slips - s0, 32'd0);
    send(10'h100, 1'b1);
    idle(2);
    chk("slip_pulse_at_64", bus.bitslip_out, 1'b1);
    idle(1);
    chk("single_slip_pulse", slips - s0, 32'd1);
    repeat (16) send(TOK, 1'b1);
    repeat (3) send(TOK, 1'b1);
    idle(2);
    chk("slip_wait_ignores_tokens", bus.locked_out, 1'b0);
    send(TOK, 1'b1);
    idle(2);
    chk("lock_after_slip_wait", bus.locked_out, 1'b1);
    idle(1);
    chk("no_extra_slip", slips - s0, 32'd1);

    idle(4);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
